sha2_pad_gen: RTL and testbench
===============================

// Module: sha2_pad_gen
// PURPOSE
//  Parametrised SHA-2 message padder. Sits between the message FIFO and the SHA-2 compression core.
//  Forwards message words, then appends the 0x80 marker, zero fill and the big-endian bit length.
//  WordW=32 gives SHA-224/256 framing; WordW=64 gives SHA-384/512 framing.
//  Handles byte-granular tails through a per-byte strobe, and supports abort mid-message.
// PARAMETERS
//  WordW  32  datapath word width; legal values are 32 or 64; one block = 16 words
//  LenW   2*WordW  width of message_length (bits); the length field occupies the last 2 words of a block
// PORTS
//  clk_i              in   1       clock
//  rst_ni             in   1       asynchronous active-low reset
//  sha_en             in   1       engine enable; qualifies hash_start
//  hash_start         in   1       single-cycle pulse: begin a new message
//  hash_process       in   1       single-cycle pulse: software has pushed the whole message
//  hash_done          in   1       single-cycle pulse: digest consumed; clears the process flag
//  abort_i            in   1       single-cycle pulse: drop the current message
//  message_length     in   LenW    message length in bits; [2:0] must be 0; stable from hash_process to completion
//  fifo_rvalid        in   1       FIFO word valid
//  fifo_rdata         in   WordW   FIFO word, first byte in the MSBs
//  fifo_rstrb         in   WordW/8 valid-byte mask, contiguous from the MSB; all-ones = full word
//  fifo_rready        out  1       FIFO pop
//  shaf_rvalid        out  1       word valid to the core
//  shaf_rdata         out  WordW   word to the core
//  shaf_rready        in   1       core accept
//  msg_feed_complete  out  1       hash_process_flag && state==IDLE
//  busy_o             out  1       state!=IDLE
// BEHAVIOUR
//  Reset: state=IDLE; byte_cnt, widx, part_q, proc_flag = 0. All outputs are 0.
//  Transfer: occurs when shaf_rvalid && shaf_rready. widx (4 bits) increments on every transfer and wraps 15->0.
//  byte_cnt (LenW-3 bits): adds popcount(fifo_rstrb) on every MSG transfer.
//  proc_flag: set by hash_process; cleared by hash_done, hash_start or abort_i. Set has priority.
//  IDLE: outputs 0. Goes to MSG when sha_en && hash_start; this also clears byte_cnt and widx.
//  MSG:
//   - shaf_rdata = fifo_rdata; shaf_rvalid = fifo_rvalid; fifo_rready = shaf_rready.
//   - If fifo_rvalid and fifo_rstrb is not all-ones: no transfer; set part_q=1; go to PAD80.
//   - Else if proc_flag && byte_cnt == message_length[LenW-1:3]: no transfer; set part_q=0; go to PAD80.
//   - The partial-word check takes priority.
//  PAD80:
//   - shaf_rvalid = 1.
//   - part_q=1: output keeps the k valid FIFO bytes, byte k = 0x80, lower bytes = 0.
//     fifo_rready = shaf_rready, so the partial word is popped on transfer.
//   - part_q=0: output = 0x80 followed by zero bytes; no pop.
//   - On transfer: go to LENHI if widx==13, else go to PAD00.
//  PAD00: output 0; shaf_rvalid = 1. On transfer with widx==13 go to LENHI.
//   - Fill therefore crosses into a second block when the marker lands at widx 14 or 15.
//  LENHI: output message_length[LenW-1:WordW]. LENLO: output message_length[WordW-1:0].
//   - Each advances on transfer; LENLO returns to IDLE.
//  Length-word alignment: the LENLO transfer always has widx==15.
//  Handshake: shaf_rvalid is never withdrawn without a transfer, except on abort.
//   - shaf_rdata is stable while shaf_rvalid && !shaf_rready.
//  hash_start outside IDLE: ignored.
//  abort_i in any state: next cycle IDLE; counters and part_q cleared; proc_flag cleared.
//   - No FIFO pop occurs in the abort cycle. The FIFO contents are the owner's to flush.
//   - abort_i takes priority over all transitions, including simultaneous hash_start.
//  Latency: MSG is combinational pass-through (0 cycles). The padding decision costs 1 cycle with no transfer.
// TESTING
//  W=32, "abc": word 0x61626300 strb 1110, len 0x18 -> 0x61626380, 13x0, 0x0, 0x18; 16 transfers; then IDLE.
//  W=32, empty message (hash_start, hash_process, len 0) -> 0x80000000, 13x0, 0x0, 0x0.
//  W=32, 56-byte message (14 full words) -> 14 msg words, 0x80000000, 0, 14x0, 0x0, 0x1C0; 32 transfers.
//  W=64, "abc" strb 11100000 -> 0x6162638000000000, 13x0, 0x0, 0x18.
//  Random shaf_rready backpressure, 0-5 stall cycles -> data held stable; sequence identical to the no-stall case.
//  abort_i in PAD00 at widx 7 -> busy_o=0 next cycle, no pop. Next message pads correctly from widx 0.

Source files
------------

// File: rtl/sha2_pad_gen.sv
// sha2_pad_gen: SHA-2 message padder placed between the message FIFO and the
// compression core. Forwards message words, then appends the 0x80 marker,
// zero fill and the big-endian bit length so that every message ends on a
// 16-word block boundary.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no message in flight, all outputs low
//   S_MSG   | FIFO words passed straight through to the core
//   S_PAD80 | marker word: partial tail + 0x80, or a bare 0x80 word
//   S_PAD00 | zero fill until word index 13 has been sent
//   S_LENHI | upper word of the bit length (word index 14)
//   S_LENLO | lower word of the bit length (word index 15)
module sha2_pad_gen #(
  parameter int WordW = 32,
  parameter int LenW  = 2 * WordW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sha_en,
  input  logic               hash_start,
  input  logic               hash_process,
  input  logic               hash_done,
  input  logic               abort_i,
  input  logic [LenW-1:0]    message_length,
  input  logic               fifo_rvalid,
  input  logic [WordW-1:0]   fifo_rdata,
  input  logic [WordW/8-1:0] fifo_rstrb,
  output logic               fifo_rready,
  output logic               shaf_rvalid,
  output logic [WordW-1:0]   shaf_rdata,
  input  logic               shaf_rready,
  output logic               msg_feed_complete,
  output logic               busy_o
);

  localparam int NB = WordW / 8;
  localparam int CW = LenW - 3;
  localparam int PW = $clog2(NB) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_PAD80,
    S_PAD00,
    S_LENHI,
    S_LENLO
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      widx_q;
  logic [CW-1:0]   byte_cnt_q;
  logic            part_q;
  logic            proc_flag_q;

  logic            xfer;
  logic            start_ok;
  logic            msg_partial;
  logic            msg_end;
  logic [NB-1:0]   strb_up;
  logic [WordW-1:0] pad_partial;
  logic            len_bits_unused;

  function automatic logic [PW-1:0] popcnt(input logic [NB-1:0] s);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < NB; i++) c = c + PW'(s[i]);
    return c;
  endfunction

  // The length is byte-aligned; its low three bits carry no information.
  assign len_bits_unused = ^message_length[2:0];

  assign start_ok    = sha_en && hash_start;
  assign msg_partial = fifo_rvalid && !(&fifo_rstrb);
  assign msg_end     = proc_flag_q && (byte_cnt_q == message_length[LenW-1:3]);
  assign xfer        = shaf_rvalid && shaf_rready;

  // Marker byte sits just below the last valid byte: first cleared strobe bit
  // whose upper neighbour is set (or the MSB byte when no byte is valid).
  assign strb_up = {1'b1, fifo_rstrb[NB-1:1]};

  // Partial tail word: keep valid bytes, insert 0x80, clear the rest.
  always_comb begin
    pad_partial = '0;
    for (int j = 0; j < NB; j++) begin
      if (fifo_rstrb[j]) pad_partial[j*8 +: 8] = fifo_rdata[j*8 +: 8];
      else if (strb_up[j]) pad_partial[j*8 +: 8] = 8'h80;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start_ok) state_d = S_MSG;
        S_MSG:   if (msg_partial || msg_end) state_d = S_PAD80;
        S_PAD80: if (xfer) state_d = (widx_q == 4'd13) ? S_LENHI : S_PAD00;
        S_PAD00: if (xfer && widx_q == 4'd13) state_d = S_LENHI;
        S_LENHI: if (xfer) state_d = S_LENLO;
        S_LENLO: if (xfer) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic; the padding decision cycle in S_MSG presents nothing so a
  // word is never offered and then withdrawn.
  always_comb begin
    shaf_rvalid = 1'b0;
    shaf_rdata  = '0;
    fifo_rready = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_MSG: begin
        shaf_rdata = fifo_rdata;
        if (!msg_partial && !msg_end) begin
          shaf_rvalid = fifo_rvalid;
          fifo_rready = shaf_rready;
        end
      end
      S_PAD80: begin
        shaf_rvalid = 1'b1;
        if (part_q) begin
          shaf_rdata  = pad_partial;
          fifo_rready = shaf_rready;
        end else begin
          shaf_rdata  = {8'h80, {(WordW-8){1'b0}}};
        end
      end
      S_PAD00: shaf_rvalid = 1'b1;
      S_LENHI: begin
        shaf_rvalid = 1'b1;
        shaf_rdata  = message_length[LenW-1 -: WordW];
      end
      S_LENLO: begin
        shaf_rvalid = 1'b1;
        shaf_rdata  = message_length[WordW-1:0];
      end
      default: ;
    endcase
    if (abort_i) begin
      shaf_rvalid = 1'b0;
      fifo_rready = 1'b0;
    end
  end

  // Word index, byte count and partial-tail flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      widx_q     <= '0;
      byte_cnt_q <= '0;
      part_q     <= 1'b0;
    end else if (abort_i) begin
      widx_q     <= '0;
      byte_cnt_q <= '0;
      part_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_ok) begin
        widx_q     <= '0;
        byte_cnt_q <= '0;
      end else if (xfer) begin
        widx_q <= widx_q + 4'd1;
      end
      if (state_q == S_MSG && xfer) byte_cnt_q <= byte_cnt_q + CW'(popcnt(fifo_rstrb));
      if (state_q == S_MSG) begin
        if (msg_partial)  part_q <= 1'b1;
        else if (msg_end) part_q <= 1'b0;
      end
    end
  end

  // Software "message fully pushed" flag; a set wins over any clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              proc_flag_q <= 1'b0;
    else if (hash_process)                    proc_flag_q <= 1'b1;
    else if (hash_done || hash_start || abort_i) proc_flag_q <= 1'b0;
  end

  assign msg_feed_complete = proc_flag_q && (state_q == S_IDLE);
  assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha2_pad_gen.sv
// tb_sha2_pad_gen: scoreboard bench for the SHA-2 padder. Expected padded
// words come from the byte-level padding rule (message, 0x80, zeros to 56 mod
// 64 bytes, 64-bit length) and are compared as the core side accepts words.
module tb_sha2_pad_gen;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } fword_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_ni, sha_en, hash_start, hash_process, hash_done, abort_i;
  logic [63:0] message_length;
  logic        fifo_rvalid;
  logic [31:0] fifo_rdata;
  logic [3:0]  fifo_rstrb;
  logic        fifo_rready;
  logic        shaf_rvalid;
  logic [31:0] shaf_rdata;
  logic        shaf_rready;
  logic        msg_feed_complete, busy_o;

  logic         hash_start64, hash_process64, hash_done64, abort64;
  logic [127:0] message_length64;
  logic         fifo_rvalid64;
  logic [63:0]  fifo_rdata64;
  logic [7:0]   fifo_rstrb64;
  logic         fifo_rready64;
  logic         shaf_rvalid64;
  logic [63:0]  shaf_rdata64;
  logic         shaf_rready64;
  logic         feed_complete64, busy64;

  sha2_pad_gen #(.WordW(32)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sha_en(sha_en), .hash_start(hash_start),
    .hash_process(hash_process), .hash_done(hash_done), .abort_i(abort_i),
    .message_length(message_length), .fifo_rvalid(fifo_rvalid),
    .fifo_rdata(fifo_rdata), .fifo_rstrb(fifo_rstrb), .fifo_rready(fifo_rready),
    .shaf_rvalid(shaf_rvalid), .shaf_rdata(shaf_rdata), .shaf_rready(shaf_rready),
    .msg_feed_complete(msg_feed_complete), .busy_o(busy_o)
  );

  sha2_pad_gen #(.WordW(64)) u_dut64 (
    .clk_i(clk_i), .rst_ni(rst_ni), .sha_en(sha_en), .hash_start(hash_start64),
    .hash_process(hash_process64), .hash_done(hash_done64), .abort_i(abort64),
    .message_length(message_length64), .fifo_rvalid(fifo_rvalid64),
    .fifo_rdata(fifo_rdata64), .fifo_rstrb(fifo_rstrb64), .fifo_rready(fifo_rready64),
    .shaf_rvalid(shaf_rvalid64), .shaf_rdata(shaf_rdata64), .shaf_rready(shaf_rready64),
    .msg_feed_complete(feed_complete64), .busy_o(busy64)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp64_q[$];
  fword_t      fifo_q[$];
  bit          ignore_out = 1'b0;
  bit          bp_en = 1'b0;
  int          abort_xfers = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // FIFO source, core-side backpressure and scoreboard monitor (32-bit DUT).
  initial begin : bus32
    logic        do_pop;
    logic        hold_pend;
    logic [31:0] hold_data;
    int          stall;
    hold_pend   = 1'b0;
    hold_data   = '0;
    stall       = 0;
    fifo_rvalid = 1'b0;
    fifo_rdata  = '0;
    fifo_rstrb  = '0;
    shaf_rready = 1'b0;
    forever begin
      @(negedge clk_i);
      if (hold_pend) begin
        check("hold_valid", shaf_rvalid, 1);
        check("hold_data", shaf_rdata, hold_data);
      end
      if (shaf_rvalid && shaf_rready) begin
        if (ignore_out) abort_xfers++;
        else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got 0x%0h, expected no transfer at %0t", shaf_rdata, $time);
        end else check("word", shaf_rdata, exp_q.pop_front());
      end
      hold_pend = shaf_rvalid && !shaf_rready && !abort_i;
      hold_data = shaf_rdata;
      do_pop    = fifo_rvalid && fifo_rready;
      @(posedge clk_i);
      #1;
      if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_rvalid = (fifo_q.size() > 0);
      if (fifo_q.size() > 0) begin
        fifo_rdata = fifo_q[0].d;
        fifo_rstrb = fifo_q[0].s;
      end else begin
        fifo_rdata = '0;
        fifo_rstrb = '0;
      end
      if (!bp_en) shaf_rready = 1'b1;
      else if (stall > 0) begin
        shaf_rready = 1'b0;
        stall--;
      end else begin
        shaf_rready = 1'b1;
        stall = $urandom_range(0, 5);
      end
    end
  end

  // Monitor and single-word FIFO for the 64-bit DUT.
  initial begin : bus64
    logic pop64;
    shaf_rready64 = 1'b1;
    forever begin
      @(negedge clk_i);
      if (shaf_rvalid64 && shaf_rready64) begin
        if (exp64_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL w64_extra_word: got 0x%0h, expected no transfer", shaf_rdata64);
        end else check("w64_word", shaf_rdata64, exp64_q.pop_front());
      end
      pop64 = fifo_rvalid64 && fifo_rready64;
      @(posedge clk_i);
      #1;
      if (pop64) fifo_rvalid64 = 1'b0;
    end
  end

  task automatic start_msg(input byte_q_t msg, input bit expect_out);
    byte_q_t     pad;
    fword_t      fw;
    int          nb;
    logic [63:0] len;
    nb  = msg.size();
    len = 64'(nb) * 64'd8;
    message_length = len;
    hash_start     = 1'b1;
    for (int w = 0; w * 4 < nb; w++) begin
      fw.d = $urandom;
      fw.s = '0;
      for (int j = 0; j < 4; j++) begin
        if (w * 4 + j < nb) begin
          fw.d[31-8*j -: 8] = msg[w*4+j];
          fw.s[3-j]         = 1'b1;
        end
      end
      fifo_q.push_back(fw);
    end
    if (expect_out) begin
      pad = msg;
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      for (int k = 7; k >= 0; k--) pad.push_back(len[8*k +: 8]);
      for (int i = 0; i < pad.size(); i += 4)
        exp_q.push_back({32'h0, pad[i], pad[i+1], pad[i+2], pad[i+3]});
    end
    tick();
    hash_start = 1'b0;
  endtask

  task automatic finish_msg(input string tag);
    int cyc;
    repeat ($urandom_range(0, 10)) tick();
    hash_process = 1'b1;
    tick();
    hash_process = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || busy_o) && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (cyc >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy=%0b, %0d words still expected", tag, busy_o, exp_q.size());
      exp_q.delete();
    end
    check({tag, "_fifo_drained"}, fifo_q.size(), 0);
    check({tag, "_feed_complete"}, msg_feed_complete, 1);
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    check({tag, "_feed_cleared"}, msg_feed_complete, 0);
  endtask

  task automatic run_msg(input byte_q_t msg, input string tag);
    start_msg(msg, 1'b1);
    finish_msg(tag);
  endtask

  task automatic abort_test(input int nbytes, input int after_xfers, input string tag);
    byte_q_t m;
    int      cyc;
    m = {};
    for (int i = 0; i < nbytes; i++) m.push_back(8'($urandom));
    ignore_out  = 1'b1;
    abort_xfers = 0;
    start_msg(m, 1'b0);
    hash_process = 1'b1;
    tick();
    hash_process = 1'b0;
    cyc = 0;
    while (abort_xfers < after_xfers && cyc < 500) begin
      @(posedge clk_i);
      cyc++;
    end
    if (cyc >= 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d transfers, expected %0d", tag, abort_xfers, after_xfers);
    end
    #2;
    abort_i = 1'b1;
    @(negedge clk_i);
    check({tag, "_no_pop"}, fifo_rready, 0);
    @(posedge clk_i);
    #2;
    abort_i = 1'b0;
    check({tag, "_idle"}, busy_o, 0);
    check({tag, "_flag_cleared"}, msg_feed_complete, 0);
    fifo_q.delete();
    tick();
    ignore_out = 1'b0;
  endtask

  task automatic run64();
    int cyc;
    exp64_q.push_back(64'h6162638000000000);
    repeat (13) exp64_q.push_back(64'h0);
    exp64_q.push_back(64'h0);
    exp64_q.push_back(64'h18);
    message_length64 = 128'h18;
    hash_start64     = 1'b1;
    fifo_rvalid64    = 1'b1;
    fifo_rdata64     = 64'h6162635A5A5A5A5A;
    fifo_rstrb64     = 8'b11100000;
    tick();
    hash_start64   = 1'b0;
    hash_process64 = 1'b1;
    tick();
    hash_process64 = 1'b0;
    cyc = 0;
    while ((exp64_q.size() != 0 || busy64) && cyc < 300) begin
      tick();
      cyc++;
    end
    check("w64_words_left", exp64_q.size(), 0);
    check("w64_idle", busy64, 0);
    check("w64_tail_popped", fifo_rvalid64, 0);
    check("w64_feed_complete", feed_complete64, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    byte_q_t m;
    rst_ni           = 1'b0;
    sha_en           = 1'b1;
    hash_start       = 1'b0;
    hash_process     = 1'b0;
    hash_done        = 1'b0;
    abort_i          = 1'b0;
    message_length   = '0;
    hash_start64     = 1'b0;
    hash_process64   = 1'b0;
    hash_done64      = 1'b0;
    abort64          = 1'b0;
    message_length64 = '0;
    fifo_rvalid64    = 1'b0;
    fifo_rdata64     = '0;
    fifo_rstrb64     = '0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_shaf_rvalid", shaf_rvalid, 0);
    check("rst_shaf_rdata", shaf_rdata, 0);
    check("rst_fifo_rready", fifo_rready, 0);
    check("rst_busy", busy_o, 0);
    check("rst_feed_complete", msg_feed_complete, 0);
    check("rst_w64_valid", shaf_rvalid64, 0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    tick();

    bp_en = 1'b0;
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, "abc");
    m = {};
    run_msg(m, "empty");
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
    run_msg(m, "len56");

    abort_test(0, 7, "abort_pad00");
    abort_test(80, 3, "abort_msg");
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, "abc_after_abort");

    bp_en = 1'b1;
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, "abc_stall");
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
    run_msg(m, "len56_stall");
    for (int n = 0; n < 30; n++) begin
      m = {};
      for (int i = 0, lim = $urandom_range(0, 130); i < lim; i++) m.push_back(8'($urandom));
      run_msg(m, "random");
    end
    bp_en = 1'b0;

    run64();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
